// File: rtl/cnn_stage_sequencer.sv
// cnn_stage_sequencer: frame-level controller for the 1-D CNN stage chain.
// Optional per-stage watchdog: define CNN_SEQ_WATCHDOG_EN.
module cnn_stage_sequencer #(
    parameter int NUM_STAGES  = 5,
    parameter int CLASS_W     = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic [CLASS_W-1:0]    class_in,
    input  logic                  result_ready,
    output logic [NUM_STAGES-1:0] stage_run,
    output logic                  busy,
    output logic                  result_valid,
    output logic [CLASS_W-1:0]    result_class,
    output logic [CNT_W-1:0]      frame_cycles,
    output logic                  start_pending
`ifdef CNN_SEQ_WATCHDOG_EN
    ,
    output logic                  timeout_err,
    output logic [3:0]            err_stage
`endif
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CAPTURE,
        S_HOLD,
        S_FLUSH
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [NUM_STAGES-1:0]   run_q;
    logic                    busy_q;
    logic                    valid_q;
    logic [CLASS_W-1:0]      class_q;
    logic [CNT_W-1:0]        fc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    pend_q;
    logic                    pend_d;
    logic                    done_cur;

`ifdef CNN_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;
    logic            wd_hit;
    logic            to_q;
    logic [3:0]      err_q;
`endif

    // Saturating latency count, start queueing, and done flag of the active stage
    always_comb begin
        cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        pend_d   = pend_q | (start & busy_q);
        done_cur = stage_done[idx_q];
`ifdef CNN_SEQ_WATCHDOG_EN
        wd_hit   = (wd_q == WD_W'(TIMEOUT_CYC - 1));
`endif
    end

    // Frame sequencer: launch, per-stage handoff, capture, hold, flush
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            run_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            class_q <= '0;
            fc_q    <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
`ifdef CNN_SEQ_WATCHDOG_EN
            wd_q    <= '0;
            to_q    <= 1'b0;
            err_q   <= '0;
`endif
        end else begin
`ifdef CNN_SEQ_WATCHDOG_EN
            to_q <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (start || pend_q) begin
                        state_q <= S_RUN;
                        idx_q   <= '0;
                        run_q   <= NUM_STAGES'(1);
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
`ifdef CNN_SEQ_WATCHDOG_EN
                        wd_q    <= '0;
`endif
                    end
                end
                S_RUN: begin
                    cnt_q  <= cnt_d;
                    pend_q <= pend_d;
                    if (done_cur) begin
                        if (idx_q == LAST) begin
                            state_q <= S_CAPTURE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            run_q <= {run_q[NUM_STAGES-2:0], 1'b1};
                        end
`ifdef CNN_SEQ_WATCHDOG_EN
                        wd_q <= '0;
                    end else if (wd_hit) begin
                        to_q    <= 1'b1;
                        err_q   <= 4'(idx_q);
                        state_q <= S_FLUSH;
                    end else begin
                        wd_q <= wd_q + 1'b1;
`endif
                    end
                end
                S_CAPTURE: begin
                    class_q <= class_in;
                    fc_q    <= cnt_q;
                    valid_q <= 1'b1;
                    pend_q  <= pend_d;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    pend_q <= pend_d;
                    if (result_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    run_q   <= '0;
                    busy_q  <= pend_d;
                    pend_q  <= pend_d;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stage_run     = run_q;
    assign busy          = busy_q;
    assign result_valid  = valid_q;
    assign result_class  = class_q;
    assign frame_cycles  = fc_q;
    assign start_pending = pend_q;
`ifdef CNN_SEQ_WATCHDOG_EN
    assign timeout_err   = to_q;
    assign err_stage     = err_q;
`endif

endmodule
